frontend_cmd_queue: RTL and testbench
=====================================

# frontend_cmd_queue

In-order command/write-data queue placed directly upstream of the command scheduler. It accepts frontend commands (`frontend_command_t`) with their write data from the host side. It presents them to the scheduler on the `valid` / `ba_cmd_pm` handshake. It also throttles READ issue so that at most `MAX_RD_OUTSTANDING` reads are awaiting `read_data_valid`.

## Interface

Parameters:
- `DEPTH`, 8: number of queue entries; a power of two, at least 2.
- `CMD_W`, `` `FRONTEND_CMD_BITS ``: command width.
- `DATA_W`, `` `DQ_BITS*8 ``: write data width.
- `MAX_RD_OUTSTANDING`, 16: maximum number of issued READs not yet returned.

Ports:
- `clk`, in, 1: the only clock.
- `power_on_rst_n`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: host command valid.
- `in_ready`, out, 1: queue can accept a command.
- `in_command`, in, `CMD_W`: host command, `frontend_command_t` layout.
- `in_write_data`, in, `DATA_W`: host write data; meaningful only when `op_type == OP_WRITE`.
- `valid`, out, 1: command valid toward the scheduler.
- `ba_cmd_pm`, in, 1: scheduler ready.
- `command`, out, `CMD_W`: head command.
- `write_data`, out, `DATA_W`: head write data; 0 for non-write commands.
- `read_data_valid`, in, 1: one READ beat returned by the scheduler.
- `count`, out, `$clog2(DEPTH+1)`: current occupancy.
- `rd_outstanding`, out, `$clog2(MAX_RD_OUTSTANDING+1)`: number of issued READs not yet returned.
- `rd_underflow_err`, out, 1: sticky flag, set when a return arrives with nothing outstanding.

## Operation

Storage:
- Circular array of {command, write_data}, indexed by `wr_ptr` and `rd_ptr`, each `$clog2(DEPTH)` bits, wrapping naturally.
- Write data is stored as 0 when the incoming `op_type != OP_WRITE`.

Handshakes:
- `in_ready = (count < DEPTH)`, combinational.
- Push occurs when `in_valid & in_ready`.
- The head is first-word-fall-through: `command` and `write_data` are read directly from `mem[rd_ptr]`.
- `valid = (count != 0) & ~rd_block`.
- `rd_block = (head op_type == OP_READ) & (rd_outstanding == MAX_RD_OUTSTANDING)`.
- Pop occurs when `valid & ba_cmd_pm`.
- While `valid` is 0, `command` and `write_data` are driven to 0.

Occupancy:
- Push only: +1. Pop only: −1. Push and pop together: unchanged.
- When full there is no push, because `in_ready = 0`. A pop while full frees exactly one entry, which is usable on the next cycle.

READ throttle counter:
- A popped READ increments `rd_outstanding`.
- `read_data_valid` decrements it.
- Both in the same cycle: unchanged.
- `read_data_valid` while the counter is 0: counter stays 0 and `rd_underflow_err` is set.
- The counter saturates at `MAX_RD_OUTSTANDING`. The gating prevents any overflow.

Ordering:
- Strictly in order; a blocked READ head also blocks every command behind it.
- WRITEs and other op_types never consume throttle credits.

Reset (`power_on_rst_n` low, at any time):
- Pointers, `count`, `rd_outstanding` and `rd_underflow_err` clear to 0.
- Queued contents are discarded.
- `valid = 0`, `command = 0`, `write_data = 0`, `in_ready = 1`.
- Outstanding reads in flight at reset are forgotten; returns arriving after reset set `rd_underflow_err`.

## Timing

- All state updates on `posedge clk`; reset is asynchronous.
- Queue latency: a command pushed at edge N is at the head with `valid = 1` during cycle N+1 (empty queue, not throttled).
- `in_ready` and `valid` are combinational from registered state only. The one exception is the bypass path below.
- No combinational path from `ba_cmd_pm` to `in_ready`.
- Throttle release: `read_data_valid` sampled at edge N raises `valid` for a blocked READ in cycle N+1.
- Sustained throughput is one push and one pop per cycle.

## Configuration

`CMDQ_BYPASS_EN` defined:
- Bypass applies when `count == 0`, `in_valid = 1`, `ba_cmd_pm = 1`, and the incoming command would not be throttled.
- In that case the input is driven straight to `command`, `write_data` and `valid` in the same cycle, and the handshake completes without writing the array.
- Pointers and `count` stay unchanged. A bypassed READ still increments `rd_outstanding`.
- This creates a combinational path from `in_*` and `ba_cmd_pm` to `valid` and `command`.

`CMDQ_BYPASS_EN` undefined:
- Every command passes through storage, with a minimum latency of 1 cycle.

## Test plan

1. **Reset values:** assert reset mid-traffic with 3 entries queued and 2 reads outstanding → `count = 0`, `rd_outstanding = 0`, `valid = 0`, `in_ready = 1`, `command = 0`. Then one `read_data_valid` → `rd_underflow_err = 1`.
2. **Fill, hold and drain:** push 8 WRITEs with data `row*16+col` (rows 0–7, col 0) while `ba_cmd_pm = 0` → `count = 8`, `in_ready = 0`. Raise `ba_cmd_pm` → 8 pops in order with matching `write_data`, `count` returns to 0.
3. **Simultaneous push/pop at full:** push and pop in the same cycle at `count = 8` → no push accepted, `count = 7` next cycle, `in_ready = 1`. Then push and pop together at `count = 4` → `count` stays 4.
4. **READ throttle:** `MAX_RD_OUTSTANDING = 2`, queue READ, READ, READ, WRITE, no returns → only 2 pops, `valid = 0`, WRITE stays queued behind the READ. One `read_data_valid` → third READ issues next cycle, then the WRITE follows.
5. **Same-cycle READ pop and return:** READ pop coincides with `read_data_valid` at `rd_outstanding = 1` → counter stays 1.
6. **Bypass:** with `CMDQ_BYPASS_EN`, empty queue, `in_valid = ba_cmd_pm = 1` → `valid = 1` and `command = in_command` in the same cycle, `count` stays 0. Without the macro → `valid` rises one cycle later.

Source files
------------

// File: rtl/frontend_cmd_queue_if.sv
// Host-side and scheduler-side signals of frontend_cmd_queue.
// The master view is the environment (host + scheduler); the slave view is the queue.
interface frontend_cmd_queue_if #(
    parameter int CMD_W  = 32,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 4,
    parameter int RDC_W  = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [CMD_W-1:0]  in_command;
    logic [DATA_W-1:0] in_write_data;
    logic              valid;
    logic              ba_cmd_pm;
    logic [CMD_W-1:0]  command;
    logic [DATA_W-1:0] write_data;
    logic              read_data_valid;
    logic [CNT_W-1:0]  count;
    logic [RDC_W-1:0]  rd_outstanding;
    logic              rd_underflow_err;

    modport master (
        output in_valid, in_command, in_write_data, ba_cmd_pm, read_data_valid,
        input  in_ready, valid, command, write_data, count, rd_outstanding, rd_underflow_err
    );

    modport slave (
        input  in_valid, in_command, in_write_data, ba_cmd_pm, read_data_valid,
        output in_ready, valid, command, write_data, count, rd_outstanding, rd_underflow_err
    );
endinterface

// File: rtl/frontend_cmd_queue.sv
// In-order command/write-data queue ahead of the scheduler, with a READ issue throttle.
// Define CMDQ_BYPASS_EN to let an empty queue forward the input in the same cycle.
`ifndef FRONTEND_CMD_BITS
`define FRONTEND_CMD_BITS 32
`endif
`ifndef DQ_BITS
`define DQ_BITS 8
`endif

module frontend_cmd_queue #(
    parameter int DEPTH              = 8,
    parameter int CMD_W              = `FRONTEND_CMD_BITS,
    parameter int DATA_W             = `DQ_BITS*8,
    parameter int MAX_RD_OUTSTANDING = 16
) (
    input logic                 clk,
    input logic                 power_on_rst_n,
    frontend_cmd_queue_if.slave cmd_bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int RDC_W = $clog2(MAX_RD_OUTSTANDING+1);
    // op_type is the two least-significant bits of frontend_command_t
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;

    logic [CMD_W-1:0]  cmd_mem_q  [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [RDC_W-1:0]  rd_out_q, rd_out_d;
    logic              underflow_q, underflow_d;

    logic [CMD_W-1:0]  head_cmd;
    logic [DATA_W-1:0] head_data;
    logic [DATA_W-1:0] in_data_masked;
    logic              head_is_read, in_is_read, throttled;
    logic              queue_valid, bypass, push, pop, rd_issue;

    assign head_cmd       = cmd_mem_q[rd_ptr_q];
    assign head_data      = data_mem_q[rd_ptr_q];
    assign head_is_read   = (head_cmd[1:0] == OP_READ);
    assign in_is_read     = (cmd_bus.in_command[1:0] == OP_READ);
    assign throttled      = (rd_out_q == RDC_W'(MAX_RD_OUTSTANDING));
    assign in_data_masked = (cmd_bus.in_command[1:0] == OP_WRITE) ? cmd_bus.in_write_data : '0;
    assign queue_valid    = (count_q != '0) & ~(head_is_read & throttled);

`ifdef CMDQ_BYPASS_EN
    assign bypass = (count_q == '0) & cmd_bus.in_valid & cmd_bus.ba_cmd_pm & ~(in_is_read & throttled);
`else
    assign bypass = 1'b0;
`endif

    // in_ready depends only on count_q, so ba_cmd_pm never reaches it combinationally
    assign cmd_bus.in_ready = (count_q < CNT_W'(DEPTH));
    assign push             = cmd_bus.in_valid & cmd_bus.in_ready & ~bypass;
    assign pop              = queue_valid & cmd_bus.ba_cmd_pm;
    assign rd_issue         = (pop & head_is_read) | (bypass & in_is_read);

    assign cmd_bus.valid            = queue_valid | bypass;
    assign cmd_bus.command          = queue_valid ? head_cmd  : (bypass ? cmd_bus.in_command : '0);
    assign cmd_bus.write_data       = queue_valid ? head_data : (bypass ? in_data_masked     : '0);
    assign cmd_bus.count            = count_q;
    assign cmd_bus.rd_outstanding   = rd_out_q;
    assign cmd_bus.rd_underflow_err = underflow_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q + PTR_W'(push);
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
        count_d     = count_q;
        rd_out_d    = rd_out_q;
        underflow_d = underflow_q;

        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        // An issue and a return in the same cycle cancel out
        if (rd_issue && !cmd_bus.read_data_valid) begin
            if (!throttled) begin
                rd_out_d = rd_out_q + RDC_W'(1);
            end
        end else if (!rd_issue && cmd_bus.read_data_valid) begin
            if (rd_out_q == '0) begin
                underflow_d = 1'b1;
            end else begin
                rd_out_d = rd_out_q - RDC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge power_on_rst_n) begin
        if (!power_on_rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_out_q    <= '0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_out_q    <= rd_out_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage needs no reset: entries are only visible while count_q covers them
    always_ff @(posedge clk) begin
        if (push) begin
            cmd_mem_q[wr_ptr_q]  <= cmd_bus.in_command;
            data_mem_q[wr_ptr_q] <= in_data_masked;
        end
    end
endmodule

// File: tb/tb_frontend_cmd_queue.sv
// Directed, scoreboard-checked bench for frontend_cmd_queue (DEPTH 8, two outstanding READs).
// Expectations for the same-cycle path follow CMDQ_BYPASS_EN when it is defined.
`ifndef FRONTEND_CMD_BITS
`define FRONTEND_CMD_BITS 32
`endif
`ifndef DQ_BITS
`define DQ_BITS 8
`endif

module tb_frontend_cmd_queue;
    localparam int DEPTH  = 8;
    localparam int MAX_RD = 2;
    localparam int CMD_W  = 32;
    localparam int DATA_W = 64;
    localparam int CNT_W  = 4;
    localparam int RDC_W  = 2;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;
    localparam logic [1:0] OP_REF   = 2'd3;
`ifdef CMDQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    frontend_cmd_queue_if #(.CMD_W(CMD_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .RDC_W(RDC_W)) bus ();

    frontend_cmd_queue #(
        .DEPTH(DEPTH), .CMD_W(CMD_W), .DATA_W(DATA_W), .MAX_RD_OUTSTANDING(MAX_RD)
    ) u_dut (
        .clk(clk),
        .power_on_rst_n(rst_n),
        .cmd_bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t sbQ[$];
    int     mRdOut = 0;
    bit     mUnder = 1'b0;
    int     nAsserts = 0;
    int     nFails = 0;

    function automatic logic [CMD_W-1:0] mkCmd(input int tag, input logic [1:0] op);
        logic [29:0] t;
        t = 30'(tag);
        return {t, op};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs at negedge, check against the model, then advance past posedge
    task automatic applyStimulus(input bit iv, input logic [CMD_W-1:0] ic, input logic [DATA_W-1:0] id,
                                 input bit rdy, input bit rdv);
        bit     headBlk, qValid, byp, doPush, issueRd;
        entry_t inEnt, outEnt;
        @(negedge clk);
        bus.in_valid        = iv;
        bus.in_command      = ic;
        bus.in_write_data   = id;
        bus.ba_cmd_pm       = rdy;
        bus.read_data_valid = rdv;
        #1;
        checkOutput("count", 64'(bus.count), 64'(sbQ.size()));
        checkOutput("rd_outstanding", 64'(bus.rd_outstanding), 64'(mRdOut));
        checkOutput("rd_underflow_err", 64'(bus.rd_underflow_err), 64'(mUnder));
        checkOutput("in_ready", 64'(bus.in_ready), 64'(sbQ.size() < DEPTH));

        inEnt.cmd  = ic;
        inEnt.data = (ic[1:0] == OP_WRITE) ? id : '0;
        headBlk = (sbQ.size() != 0) && (sbQ[0].cmd[1:0] == OP_READ) && (mRdOut == MAX_RD);
        qValid  = (sbQ.size() != 0) && !headBlk;
        byp     = BYP && (sbQ.size() == 0) && iv && rdy && !((ic[1:0] == OP_READ) && (mRdOut == MAX_RD));
        doPush  = iv && (sbQ.size() < DEPTH) && !byp;
        checkOutput("valid", 64'(bus.valid), 64'(qValid || byp));

        issueRd = 1'b0;
        if (qValid || byp) begin
            outEnt = byp ? inEnt : sbQ[0];
            checkOutput("command", 64'(bus.command), 64'(outEnt.cmd));
            checkOutput("write_data", 64'(bus.write_data), 64'(outEnt.data));
            if (rdy) begin
                if (!byp) void'(sbQ.pop_front());
                issueRd = (outEnt.cmd[1:0] == OP_READ);
            end
        end else begin
            checkOutput("command_idle", 64'(bus.command), 64'd0);
            checkOutput("write_data_idle", 64'(bus.write_data), 64'd0);
        end
        if (doPush) sbQ.push_back(inEnt);

        if (issueRd && !rdv) begin
            mRdOut++;
        end else if (!issueRd && rdv) begin
            if (mRdOut == 0) mUnder = 1'b1;
            else mRdOut--;
        end
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input bit rdy, input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, rdy, 1'b0);
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst_n               = 1'b0;
        bus.in_valid        = 1'b0;
        bus.in_command      = '0;
        bus.in_write_data   = '0;
        bus.ba_cmd_pm       = 1'b0;
        bus.read_data_valid = 1'b0;
        #1;
        checkOutput("rst_count", 64'(bus.count), 64'd0);
        checkOutput("rst_rd_outstanding", 64'(bus.rd_outstanding), 64'd0);
        checkOutput("rst_valid", 64'(bus.valid), 64'd0);
        checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("rst_command", 64'(bus.command), 64'd0);
        checkOutput("rst_write_data", 64'(bus.write_data), 64'd0);
        checkOutput("rst_underflow", 64'(bus.rd_underflow_err), 64'd0);
        sbQ.delete();
        mRdOut = 0;
        mUnder = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.in_valid        = 1'b0;
        bus.in_command      = '0;
        bus.in_write_data   = '0;
        bus.ba_cmd_pm       = 1'b0;
        bus.read_data_valid = 1'b0;
        applyReset();

        // Reset mid-traffic: two READs issued, three entries waiting
        applyStimulus(1'b1, mkCmd(1, OP_READ), '0, 1'b0, 1'b0);
        applyStimulus(1'b1, mkCmd(2, OP_READ), '0, 1'b0, 1'b0);
        idle(1'b1, 2);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, mkCmd(10 + i, OP_WRITE), 64'(i + 1), 1'b0, 1'b0);
        checkOutput("pre_rst_count", 64'(bus.count), 64'd3);
        checkOutput("pre_rst_rd_out", 64'(bus.rd_outstanding), 64'd2);
        applyReset();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        checkOutput("underflow_after_rst", 64'(bus.rd_underflow_err), 64'd1);

        // Fill, hold and drain
        applyReset();
        for (int r = 0; r < 8; r++) applyStimulus(1'b1, mkCmd(20 + r, OP_WRITE), 64'(r * 16), 1'b0, 1'b0);
        checkOutput("full_count", 64'(bus.count), 64'd8);
        checkOutput("full_in_ready", 64'(bus.in_ready), 64'd0);
        idle(1'b1, 8);
        checkOutput("drained_count", 64'(bus.count), 64'd0);
        applyStimulus(1'b1, mkCmd(30, OP_REF), 64'hDEAD, 1'b0, 1'b0);
        idle(1'b1, 1);

        // Push and pop together at full, then at half occupancy
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, mkCmd(40 + i, OP_WRITE), 64'(256 + i), 1'b0, 1'b0);
        applyStimulus(1'b1, mkCmd(99, OP_WRITE), 64'hAA, 1'b1, 1'b0);
        checkOutput("full_pushpop_count", 64'(bus.count), 64'd7);
        checkOutput("full_pushpop_in_ready", 64'(bus.in_ready), 64'd1);
        idle(1'b1, 3);
        applyStimulus(1'b1, mkCmd(50, OP_WRITE), 64'h55, 1'b1, 1'b0);
        checkOutput("half_pushpop_count", 64'(bus.count), 64'd4);
        idle(1'b1, 4);

        // READ throttle holds the head and everything behind it
        applyReset();
        applyStimulus(1'b1, mkCmd(61, OP_READ), '0, 1'b0, 1'b0);
        applyStimulus(1'b1, mkCmd(62, OP_READ), '0, 1'b0, 1'b0);
        applyStimulus(1'b1, mkCmd(63, OP_READ), '0, 1'b0, 1'b0);
        applyStimulus(1'b1, mkCmd(64, OP_WRITE), 64'hBEEF, 1'b0, 1'b0);
        idle(1'b1, 4);
        checkOutput("throttle_count", 64'(bus.count), 64'd2);
        checkOutput("throttle_rd_out", 64'(bus.rd_outstanding), 64'd2);
        checkOutput("throttle_valid", 64'(bus.valid), 64'd0);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
        checkOutput("release_valid", 64'(bus.valid), 64'd1);
        checkOutput("release_command", 64'(bus.command), 64'(mkCmd(63, OP_READ)));
        idle(1'b1, 2);
        checkOutput("throttle_done_count", 64'(bus.count), 64'd0);
        checkOutput("throttle_done_rd_out", 64'(bus.rd_outstanding), 64'd2);

        // READ pop coinciding with a return
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        applyStimulus(1'b1, mkCmd(70, OP_READ), '0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
        checkOutput("same_cycle_rd_out", 64'(bus.rd_outstanding), 64'd1);

        // Empty queue with scheduler ready: same-cycle forward only in the bypass build
        applyReset();
        applyStimulus(1'b1, mkCmd(80, OP_WRITE), 64'h1234, 1'b1, 1'b0);
`ifdef CMDQ_BYPASS_EN
        checkOutput("bypass_count", 64'(bus.count), 64'd0);
        applyStimulus(1'b1, mkCmd(81, OP_READ), '0, 1'b1, 1'b0);
        checkOutput("bypass_read_count", 64'(bus.count), 64'd0);
        checkOutput("bypass_read_rd_out", 64'(bus.rd_outstanding), 64'd1);
`else
        checkOutput("nobypass_count", 64'(bus.count), 64'd1);
        checkOutput("nobypass_valid", 64'(bus.valid), 64'd1);
        idle(1'b1, 1);
        applyStimulus(1'b1, mkCmd(81, OP_READ), '0, 1'b1, 1'b0);
        checkOutput("nobypass_read_count", 64'(bus.count), 64'd1);
        checkOutput("nobypass_read_rd_out", 64'(bus.rd_outstanding), 64'd0);
`endif
        idle(1'b1, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end
endmodule
